// File: rtl/eq_lock_pkg.sv
// Shared types and default parameters for the comparator lock tracker.
package eq_lock_pkg;

    localparam int unsigned LOCK_CNT_DEF   = 4;
    localparam int unsigned UNLOCK_CNT_DEF = 3;
    localparam int unsigned CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        StSearch  = 2'd0,
        StAcquire = 2'd1,
        StLocked  = 2'd2,
        StHold    = 2'd3
    } lock_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/eq_lock_tracker.sv
// Lock/unlock hysteresis over qualified comparator samples, with saturating
// run-length and match/mismatch statistics.
module eq_lock_tracker
    import eq_lock_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
    parameter int unsigned UNLOCK_CNT = UNLOCK_CNT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             eq,
    input  logic             clear,
    output logic             locked,
    output logic             lock_event,
    output logic             unlock_event,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] match_total,
    output logic [CNT_W-1:0] mismatch_total
);

    localparam logic [CNT_W-1:0] LockCntW   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UnlockCntW = CNT_W'(UNLOCK_CNT);

    lock_state_e      state_d, state_q;
    logic [CNT_W-1:0] miss_d, miss_q;
    logic             locked_d, locked_q;
    logic             lock_event_d, lock_event_q;
    logic             unlock_event_d, unlock_event_q;

    logic             sample_hit, sample_miss;
    logic [CNT_W-1:0] run_inc, miss_inc;
    logic             hit_lock, hit_unlock;

    assign sample_hit  = in_valid & eq;
    assign sample_miss = in_valid & ~eq;

    // Lock decision looks at the run length this sample will produce.
    assign run_inc    = (run_len == {CNT_W{1'b1}}) ? run_len : run_len + CNT_W'(1);
    assign miss_inc   = miss_q + CNT_W'(1);
    assign hit_lock   = (run_inc == LockCntW);
    assign hit_unlock = (miss_inc == UnlockCntW);

    always_comb begin
        state_d        = state_q;
        miss_d         = miss_q;
        lock_event_d   = 1'b0;
        unlock_event_d = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                StSearch: begin
                    if (eq) begin
                        if (hit_lock) begin
                            state_d      = StLocked;
                            lock_event_d = 1'b1;
                        end else begin
                            state_d = StAcquire;
                        end
                    end
                end
                StAcquire: begin
                    if (!eq) begin
                        state_d = StSearch;
                    end else if (hit_lock) begin
                        state_d      = StLocked;
                        lock_event_d = 1'b1;
                    end
                end
                StLocked: begin
                    if (!eq) begin
                        if (hit_unlock) begin
                            state_d        = StSearch;
                            unlock_event_d = 1'b1;
                            miss_d         = '0;
                        end else begin
                            state_d = StHold;
                            miss_d  = miss_inc;
                        end
                    end
                end
                StHold: begin
                    if (eq) begin
                        state_d = StLocked;
                        miss_d  = '0;
                    end else if (hit_unlock) begin
                        state_d        = StSearch;
                        unlock_event_d = 1'b1;
                        miss_d         = '0;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
                default: begin
                    state_d = StSearch;
                    miss_d  = '0;
                end
            endcase
        end
        locked_d = (state_d == StLocked) || (state_d == StHold);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StSearch;
            miss_q         <= '0;
            locked_q       <= 1'b0;
            lock_event_q   <= 1'b0;
            unlock_event_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            miss_q         <= miss_d;
            locked_q       <= locked_d;
            lock_event_q   <= lock_event_d;
            unlock_event_q <= unlock_event_d;
        end
    end

    assign state        = state_q;
    assign locked       = locked_q;
    assign lock_event   = lock_event_q;
    assign unlock_event = unlock_event_q;

    // A valid mismatch breaks the streak, so it acts as the run-length clear.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_run_len (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (sample_hit),
        .clr_i   (sample_miss),
        .count_o (run_len)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_total (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (sample_hit),
        .clr_i   (clear),
        .count_o (match_total)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_mismatch_total (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (sample_miss),
        .clr_i   (clear),
        .count_o (mismatch_total)
    );

endmodule

// File: tb/tb_eq_lock_tracker.sv
// Drives three tracker configurations with one stimulus stream and compares
// every output against an integer-arithmetic reference model each cycle.
module tb_eq_lock_tracker;

    logic clk = 1'b0;
    logic rst, in_valid, eq, clear;

    always #5 clk = ~clk;

    logic        lk0, le0, ue0;
    logic [1:0]  st0;
    logic [15:0] rl0, mt0, mm0;
    logic        lk1, le1, ue1;
    logic [1:0]  st1;
    logic [3:0]  rl1, mt1, mm1;
    logic        lk2, le2, ue2;
    logic [1:0]  st2;
    logic [7:0]  rl2, mt2, mm2;

    eq_lock_tracker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .eq(eq), .clear(clear),
        .locked(lk0), .lock_event(le0), .unlock_event(ue0), .state(st0),
        .run_len(rl0), .match_total(mt0), .mismatch_total(mm0)
    );

    eq_lock_tracker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .eq(eq), .clear(clear),
        .locked(lk1), .lock_event(le1), .unlock_event(ue1), .state(st1),
        .run_len(rl1), .match_total(mt1), .mismatch_total(mm1)
    );

    eq_lock_tracker #(.LOCK_CNT(1), .UNLOCK_CNT(1), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .eq(eq), .clear(clear),
        .locked(lk2), .lock_event(le2), .unlock_event(ue2), .state(st2),
        .run_len(rl2), .match_total(mt2), .mismatch_total(mm2)
    );

    // Model: unbounded streak counts; outputs are capped only when compared.
    int  p_lock[3]   = '{4, 4, 1};
    int  p_unlock[3] = '{3, 3, 1};
    int  p_max[3]    = '{65535, 15, 255};
    int  m_run[3], m_miss[3], m_mt[3], m_mm[3];
    bit  m_locked[3], m_le[3], m_ue[3];

    int n_vec = 0;
    int n_err = 0;

    function automatic int cap(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_update(input int k, input bit r, input bit v, input bit e,
                                input bit c);
        m_le[k] = 1'b0;
        m_ue[k] = 1'b0;
        if (r) begin
            m_run[k] = 0; m_miss[k] = 0; m_mt[k] = 0; m_mm[k] = 0;
            m_locked[k] = 1'b0;
            return;
        end
        if (v) begin
            if (e) begin
                m_run[k]++;
                if (m_locked[k]) begin
                    m_miss[k] = 0;
                end else if (m_run[k] == p_lock[k]) begin
                    m_locked[k] = 1'b1;
                    m_le[k]     = 1'b1;
                end
                if (!c) m_mt[k]++;
            end else begin
                m_run[k] = 0;
                if (m_locked[k]) begin
                    m_miss[k]++;
                    if (m_miss[k] == p_unlock[k]) begin
                        m_locked[k] = 1'b0;
                        m_miss[k]   = 0;
                        m_ue[k]     = 1'b1;
                    end
                end
                if (!c) m_mm[k]++;
            end
        end
        if (c) begin
            m_mt[k] = 0;
            m_mm[k] = 0;
        end
    endtask

    function automatic int exp_state(input int k);
        if (!m_locked[k]) return (m_run[k] > 0) ? 1 : 0;
        return (m_miss[k] > 0) ? 3 : 2;
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] at %0t: observed %0d expected %0d", tag, k, $time, obs, exp);
        end
    endtask

    task automatic check_inst(input int k, input logic lk, input logic le, input logic ue,
                              input logic [1:0] st, input logic [31:0] rl,
                              input logic [31:0] mt, input logic [31:0] mm);
        check("locked", k, {31'd0, lk}, {31'd0, m_locked[k]});
        check("lock_event", k, {31'd0, le}, {31'd0, m_le[k]});
        check("unlock_event", k, {31'd0, ue}, {31'd0, m_ue[k]});
        check("state", k, {30'd0, st}, exp_state(k));
        check("run_len", k, rl, cap(m_run[k], p_max[k]));
        check("match_total", k, mt, cap(m_mt[k], p_max[k]));
        check("mismatch_total", k, mm, cap(m_mm[k], p_max[k]));
    endtask

    task automatic step(input bit r, input bit v, input bit e, input bit c);
        rst      = r;
        in_valid = v;
        eq       = e;
        clear    = c;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_update(k, r, v, e, c);
        #1;
        check_inst(0, lk0, le0, ue0, st0, 32'(rl0), 32'(mt0), 32'(mm0));
        check_inst(1, lk1, le1, ue1, st1, 32'(rl1), 32'(mt1), 32'(mm1));
        check_inst(2, lk2, le2, ue2, st2, 32'(rl2), 32'(mt2), 32'(mm2));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; eq = 1'b0; clear = 1'b0;

        // Reset, then idle.
        repeat (2) step(1, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0);

        // Acquire lock with 4 matches.
        repeat (4) step(0, 1, 1, 0);

        // Two misses into HOLD, then recover.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);

        // Three misses separated by idle gaps drop lock.
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Long match run saturates the narrow instance; clear with a match.
        repeat (20) step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);

        // Reset mid-acquire discards progress.
        step(1, 0, 0, 0);
        repeat (3) step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        repeat (4) step(0, 1, 1, 0);

        // Randomized traffic with alternating match-rich and miss-rich phases.
        for (int i = 0; i < 600; i++) begin
            bit r, v, e, c;
            int bias;
            bias = ((i / 60) % 2 == 0) ? 85 : 45;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 99) < 85);
            e = ($urandom_range(0, 99) < bias);
            c = ($urandom_range(0, 99) < 3);
            step(r, v, e, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eq_lock_tracker.md
Name: eq_lock_tracker

Overview:
- Downstream consumer of the 64-bit equality comparator's per-sample eq result.
- Qualifies eq with a valid strobe and runs a lock/unlock hysteresis FSM over consecutive matches and mismatches.
- Keeps saturating match and mismatch statistics, so pattern/sync-detect logic sees a stable "locked" indication instead of raw per-cycle eq.

Parameters:
- LOCK_CNT, 4, consecutive valid matches needed to enter lock (legal range 1..2^CNT_W-1)
- UNLOCK_CNT, 3, consecutive valid mismatches needed to drop lock (legal range 1..2^CNT_W-1)
- CNT_W, 16, width of all counters and statistics

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  eq is a valid comparator sample this cycle
- eq  in  1  comparator result (1 = operands equal); ignored when in_valid=0
- clear  in  1  synchronous clear of match_total/mismatch_total only
- locked  out  1  high in LOCKED and HOLD states
- lock_event  out  1  one-cycle pulse on entry to LOCKED from ACQUIRE or SEARCH
- unlock_event  out  1  one-cycle pulse on transition to SEARCH from LOCKED or HOLD
- state  out  2  current FSM state encoding
- run_len  out  CNT_W  current consecutive-match count, saturating
- match_total  out  CNT_W  valid eq=1 samples since reset/clear, saturating
- mismatch_total  out  CNT_W  valid eq=0 samples since reset/clear, saturating

Behaviour:
- One clock domain; clk, synchronous active-high rst. All outputs are registered.
- Reset values: state=SEARCH, locked=0, lock_event=0, unlock_event=0, run_len=0, match_total=0, mismatch_total=0, internal miss counter=0. A reset mid-streak discards all progress.
- Latency: a sample presented in cycle N is reflected on all outputs in cycle N+1.
- in_valid=0: FSM, run_len, miss counter and totals hold their values; lock_event and unlock_event are 0.
- States and encoding: SEARCH=0, ACQUIRE=1, LOCKED=2, HOLD=3.
- SEARCH:
  - valid&eq with LOCK_CNT=1: go to LOCKED and pulse lock_event.
  - valid&eq otherwise: go to ACQUIRE.
  - valid&!eq: stay in SEARCH.
- ACQUIRE:
  - valid&eq: when the incremented run_len equals LOCK_CNT, go to LOCKED and pulse lock_event; otherwise stay.
  - valid&!eq: go to SEARCH.
- LOCKED:
  - valid&!eq with UNLOCK_CNT=1: go to SEARCH and pulse unlock_event.
  - valid&!eq otherwise: go to HOLD with miss=1.
  - valid&eq: stay.
- HOLD:
  - valid&eq: go to LOCKED and set miss=0; no event pulse.
  - valid&!eq: miss+1; when it equals UNLOCK_CNT, go to SEARCH, pulse unlock_event and set miss=0.
- run_len: +1 on valid&eq, saturating at 2^CNT_W-1; set to 0 on valid&!eq. It continues counting after lock is reached.
- Totals: +1 on the matching sample type, saturating at all-ones. There is no wrap-around anywhere.
- clear: has priority over counting. In a clear cycle both totals become 0 and that cycle's sample is not counted in the totals. The FSM, run_len and miss counter still process that sample normally.
- lock_event and unlock_event are never high in the same cycle, and each is high for exactly one cycle per transition.

Decomposition:
- Shared package eq_lock_pkg holds:
  - state typedef and encodings (SEARCH/ACQUIRE/LOCKED/HOLD);
  - default LOCK_CNT/UNLOCK_CNT/CNT_W constants.
- One sub-module, sat_counter (CNT_W-wide, inc/clr inputs, saturate at max), is instantiated for run_len, match_total and mismatch_total.
- The FSM and miss counter stay in the top module.

Test Plan:
- rst held 2 cycles, then released with in_valid=0 -> all outputs 0, state=0, for 10 cycles.
- 4 consecutive valid eq=1 samples (defaults) -> state goes 1,1,1,2; lock_event high only in the cycle after the 4th sample; locked=1; run_len=4; match_total=4.
- From LOCKED, the sequence mismatch, mismatch, match -> HOLD, HOLD, LOCKED; no events; locked stays 1; mismatch_total=2; run_len=1.
- From LOCKED, 3 valid mismatches with in_valid=0 gaps between them -> gaps change nothing; unlock_event pulses once after the 3rd mismatch; state=0; locked=0.
- CNT_W=4 with 20 valid matches -> run_len and match_total saturate at 15 and do not wrap; a clear asserted with a valid match in the same cycle -> match_total=0 next cycle, run_len=15.
- rst asserted while in ACQUIRE with run_len=3 -> next cycle state=0, run_len=0; a following 4 matches are required to lock.
